// File: rtl/polyphase_input_pacer.sv
// Input pacer for the polyphase interpolator: buffers a bursty valid/ready stream
// and re-issues words as single-cycle pulses spaced PACE_INTERVAL cycles apart.
module polyphase_input_pacer #(
    parameter int DATA_WIDTH    = 16,
    parameter int FIFO_DEPTH    = 16,
    parameter int PACE_INTERVAL = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          enable,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          m_valid,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    // Keep the gap counter at least one bit wide so PACE_INTERVAL=1 still elaborates.
    localparam int GW = (PACE_INTERVAL > 1) ? $clog2(PACE_INTERVAL) : 1;
    localparam logic [GW-1:0] GAP_RELOAD = GW'(PACE_INTERVAL - 1);
    localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

    logic full;
    logic empty;
    logic wr_en;
    logic issue;

    always_comb begin
        full    = (count_q == DEPTH_C);
        empty   = (count_q == '0);
        s_ready = !full && !rst && !flush;
        wr_en   = s_valid && s_ready;
        issue   = (gap_q == '0) && !empty && enable && !flush;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        gap_d     = gap_q;
        m_valid_d = 1'b0;
        m_data_d  = m_data_q;

        if (flush) begin
            // m_data is deliberately held so the filter input stays stable.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            gap_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(wr_en);
            rd_ptr_d = rd_ptr_q + AW'(issue);

            if (wr_en && !issue) begin
                count_d = count_q + (AW + 1)'(1);
            end else if (!wr_en && issue) begin
                count_d = count_q - (AW + 1)'(1);
            end

            if (issue) begin
                gap_d     = GAP_RELOAD;
                m_valid_d = 1'b1;
                m_data_d  = mem_q[rd_ptr_q];
            end else if (gap_q != '0) begin
                gap_d = gap_q - GW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            gap_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    // Storage has no reset; wr_en is already gated by rst/flush through s_ready.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign fill_level = count_q;

endmodule

// File: tb/tb_polyphase_input_pacer.sv
// Self-checking bench for polyphase_input_pacer: a cycle model with a word queue as
// scoreboard for the PACE_INTERVAL=15 build, plus a PACE_INTERVAL=1 instance.
module tb_polyphase_input_pacer;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int PACE  = 15;

    logic          clk = 1'b0;
    logic          rst, flush, enable, s_valid, s_ready, m_valid;
    logic [DW-1:0] s_data, m_data;
    logic [4:0]    fill_level;

    logic          p1_rst, p1_flush, p1_enable, p1_s_valid, p1_s_ready, p1_m_valid;
    logic [DW-1:0] p1_s_data, p1_m_data;
    logic [4:0]    p1_fill_level;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    polyphase_input_pacer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PACE_INTERVAL(PACE)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .enable(enable),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_data(m_data), .fill_level(fill_level)
    );

    polyphase_input_pacer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PACE_INTERVAL(1)) u_dut_p1 (
        .clk(clk), .rst(p1_rst), .flush(p1_flush), .enable(p1_enable),
        .s_valid(p1_s_valid), .s_ready(p1_s_ready), .s_data(p1_s_data),
        .m_valid(p1_m_valid), .m_data(p1_m_data), .fill_level(p1_fill_level)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference model of the main instance, advanced once per rising edge.
    logic [DW-1:0] sb [$];
    int            gap_m     = 0;
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data  = '0;

    function automatic logic model_ready();
        return !rst && !flush && (sb.size() < DEPTH);
    endfunction

    always @(posedge clk) begin : mon_main
        logic iss;
        logic acc;
        if (rst) begin
            sb.delete();
            gap_m     = 0;
            exp_valid = 1'b0;
            exp_data  = '0;
        end else if (flush) begin
            sb.delete();
            gap_m     = 0;
            exp_valid = 1'b0;
        end else begin
            iss = (gap_m == 0) && (sb.size() > 0) && enable;
            acc = s_valid && (sb.size() < DEPTH);
            if (gap_m > 0) gap_m--;
            if (iss) begin
                exp_data  = sb.pop_front();
                exp_valid = 1'b1;
                gap_m     = PACE - 1;
            end else begin
                exp_valid = 1'b0;
            end
            if (acc) sb.push_back(s_data);
        end
        #1;
        check_eq("m_valid", 32'(m_valid), 32'(exp_valid));
        check_eq("m_data", 32'(m_data), 32'(exp_data));
        check_eq("fill_level", 32'(fill_level), 32'(sb.size()));
    end

    always @(negedge clk) begin : mon_ready
        #2;
        if (!$isunknown(rst)) check_eq("s_ready", 32'(s_ready), 32'(model_ready()));
    end

    // PACE_INTERVAL=1 instance: its FIFO never fills, so every valid cycle is a write.
    logic [DW-1:0] sb1 [$];
    int p1_pulses  = 0;
    int p1_run     = 0;
    int p1_max_run = 0;

    always @(posedge clk) begin : mon_p1
        if (p1_rst === 1'b0 && p1_s_valid) sb1.push_back(p1_s_data);
        #1;
        if (p1_m_valid === 1'b1) begin
            if (sb1.size() == 0) check_eq("p1_extra_pulse", 32'd1, 32'd0);
            else check_eq("p1_data", 32'(p1_m_data), 32'(sb1.pop_front()));
            p1_pulses++;
            p1_run++;
            if (p1_run > p1_max_run) p1_max_run = p1_run;
        end else begin
            p1_run = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one word and hold it until the model says it was taken.
    task automatic push_word(input logic [DW-1:0] d);
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int n = 0; n < 64 && !ok; n++) begin
            #2;
            ok = model_ready();
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!ok) check_eq("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_empty(input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            if (sb.size() == 0 && gap_m == 0) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) check_eq("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0;
        p1_rst = 1'b1; p1_flush = 1'b0; p1_enable = 1'b0; p1_s_valid = 1'b0; p1_s_data = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_fill", 32'(fill_level), 32'd0);
        check_eq("reset_m_valid", 32'(m_valid), 32'd0);
        check_eq("reset_m_data", 32'(m_data), 32'd0);
        check_eq("reset_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0; p1_rst = 1'b0;

        // Single word: one-edge latency from write to issue.
        enable = 1'b1;
        push_word(16'h1234);
        check_eq("t1_fill_after_write", 32'(fill_level), 32'd1);
        check_eq("t1_no_pulse_yet", 32'(m_valid), 32'd0);
        @(negedge clk);
        check_eq("t1_pulse", 32'(m_valid), 32'd1);
        check_eq("t1_data", 32'(m_data), 32'h1234);
        check_eq("t1_fill_after_issue", 32'(fill_level), 32'd0);
        @(negedge clk);
        check_eq("t1_single_cycle", 32'(m_valid), 32'd0);
        idle(20);

        // Burst of four words; pacing is checked every cycle by the model.
        for (int i = 1; i <= 4; i++) push_word(DW'(i));
        check_eq("t2_peak_fill", 32'(fill_level), 32'd3);
        wait_empty(100);
        idle(3);

        // Fill to full with output disabled, then drain while s_valid is held at full.
        enable = 1'b0;
        for (int i = 0; i < 16; i++) push_word(16'h0100 + DW'(i));
        check_eq("t3_full_level", 32'(fill_level), 32'd16);
        s_valid = 1'b1;
        s_data  = 16'h0110;
        idle(3);
        check_eq("t3_17th_refused", 32'(fill_level), 32'd16);
        check_eq("t3_ready_low", 32'(s_ready), 32'd0);
        enable = 1'b1;
        push_word(16'h0110);
        check_eq("t4_refill", 32'(fill_level), 32'd16);
        wait_empty(600);
        idle(3);

        // Flush mid-burst while the gap counter is still running.
        for (int i = 0; i < 6; i++) push_word(16'h0200 + DW'(i));
        check_eq("t5_buffered", 32'(fill_level), 32'd5);
        s_valid = 1'b1;
        s_data  = 16'h02ff;
        flush   = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        s_valid = 1'b0;
        check_eq("t5_flush_fill", 32'(fill_level), 32'd0);
        check_eq("t5_flush_m_valid", 32'(m_valid), 32'd0);
        push_word(16'h0300);
        @(negedge clk);
        check_eq("t5_post_flush_pulse", 32'(m_valid), 32'd1);
        check_eq("t5_post_flush_data", 32'(m_data), 32'h0300);
        idle(20);

        // Reset mid-burst discards buffered words; no pulse follows.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) push_word(16'h0400 + DW'(i));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        check_eq("t6_reset_fill", 32'(fill_level), 32'd0);
        check_eq("t6_reset_data", 32'(m_data), 32'd0);
        idle(5);

        // PACE_INTERVAL=1: eight consecutive writes give eight consecutive pulses.
        p1_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            p1_s_valid = 1'b1;
            p1_s_data  = 16'h0a00 + DW'(i);
            #2;
            check_eq("p1_s_ready", 32'(p1_s_ready), 32'd1);
            @(negedge clk);
        end
        p1_s_valid = 1'b0;
        idle(12);
        check_eq("p1_pulse_count", 32'(p1_pulses), 32'd8);
        check_eq("p1_max_run", 32'(p1_max_run), 32'd8);
        check_eq("p1_leftover", 32'(sb1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/polyphase_input_pacer.md
Name: polyphase_input_pacer

Overview:
- Upstream stage for polyphase_filter in interpolation mode.
- The interpolator accepts one input sample, then is busy for 2*PHASES-1 cycles (IDLE, then GAP/PULSE alternation) and ignores valid_i during that window.
- This block buffers a bursty valid/ready sample stream in a FIFO and re-issues samples as single-cycle valid pulses spaced exactly PACE_INTERVAL cycles apart, so no sample is lost at the filter input.

Parameters:
- DATA_WIDTH, 16, sample width in bits; must match the filter's DATA_WIDTH.
- FIFO_DEPTH, 16, buffer depth in words; power of two, ≥2.
- PACE_INTERVAL, 15, minimum cycles between output pulses (edge-to-edge); set to 2*PHASES-1 for the interpolator; ≥1.

Ports:
- clk, input, 1, single clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- flush, input, 1, synchronous clear of FIFO and pacer.
- enable, input, 1, 1 permits output pulses; the FIFO keeps accepting while enable=0.
- s_valid, input, 1, upstream sample valid.
- s_ready, output, 1, upstream ready; combinational = !full && !rst && !flush.
- s_data, input, DATA_WIDTH, upstream sample.
- m_valid, output, 1, single-cycle pulse to the filter's valid_i.
- m_data, output, DATA_WIDTH, sample to the filter's data_i; held stable between pulses.
- fill_level, output, $clog2(FIFO_DEPTH)+1, registered word count in the FIFO.

Behaviour:

Reset and flush:
- rst=1 (sampled at an edge): m_valid=0, m_data=0, fill_level=0, read/write pointers=0, gap counter=0. s_ready=0 while rst is high.
- Reset mid-burst discards all buffered words. No pulse is issued in the cycle after reset.
- flush has the same effect as rst on the FIFO, pointers, gap counter and m_valid. m_data is held.
- A write presented in a flush cycle is discarded; s_ready is low in that cycle.
- Priority order: rst > flush > normal operation.

FIFO:
- Write occurs when s_valid && s_ready at an edge.
- full = (fill_level == FIFO_DEPTH); empty = (fill_level == 0).
- When full, s_ready=0 even if a read happens in the same cycle (no write-through at full).
- On a simultaneous write and read, fill_level is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Data order is strictly FIFO; no word is dropped or duplicated.

Pacer:
- The gap counter (range 0..PACE_INTERVAL-1) decrements each cycle while nonzero, regardless of enable.
- Issue condition at an edge: gap counter == 0 && !empty && enable.
- On issue: pop the head word, register m_data <= head, m_valid <= 1, load gap counter with PACE_INTERVAL-1.
- Otherwise m_valid <= 0.
- m_valid is therefore never high for two consecutive cycles when PACE_INTERVAL > 1.
- With PACE_INTERVAL = 1, m_valid may stay high continuously while the FIFO is nonempty.

Latency:
- A word accepted at edge k into an empty FIFO with the gap counter at 0 and enable=1 is issued at edge k+1; m_valid is high in the cycle after edge k+1.

Back-to-back behaviour:
- While the FIFO stays nonempty and enable=1, pulses occur on edges exactly PACE_INTERVAL apart.
- If enable is deasserted, the pending count still expires. On re-enable, a pulse is issued at the first edge where enable=1 and the counter is 0.

Arithmetic:
- No data arithmetic; s_data passes bit-exact to m_data.

Test Plan:
1. Reset then a single word: rst held 3 cycles; write 0x1234 at edge 5 → m_valid pulse after edge 6 with m_data=0x1234; fill_level 1 after edge 5, 0 after edge 6.
2. Burst of 4 words (0x0001–0x0004) on consecutive cycles, PACE_INTERVAL=15 → pulses at edges E, E+15, E+30, E+45 in order; fill_level peaks at 3.
3. Fill to full: 16 writes with enable=0 → s_ready=0 once fill_level=16; a 17th s_valid is not accepted; enabling then drains all 16 words in order at 15-cycle spacing.
4. Full with simultaneous read: FIFO full, enable=1, s_valid held → no write in the issue cycle; fill_level 16→15, then a write is accepted the next cycle → 16.
5. Flush mid-burst: flush asserted with 5 words buffered and s_valid=1 → fill_level=0 next edge, the concurrent write is dropped, m_valid=0; the next write issues after 1 edge (gap counter cleared).
6. PACE_INTERVAL=1 build: 8 consecutive writes → m_valid high for 8 consecutive cycles, data in order.
